// File: rtl/mem_bus_decoder.sv
// mem_bus_decoder: picorv32 native port to rom/ram/periph decoder with timeout and error response
module mem_bus_decoder #(
  parameter logic [31:0] ROM_BASE    = 32'h0000_0000,
  parameter logic [31:0] RAM_BASE    = 32'h0001_0000,
  parameter logic [31:0] PERIPH_BASE = 32'h8000_0000,
  parameter int          SLV_AW      = 10,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic [SLV_AW-1:0] slv_addr,
  output logic [31:0]       slv_wdata,
  output logic [3:0]        slv_wstrb,
  output logic              rom_sel,
  output logic              ram_sel,
  output logic              per_sel,
  input  logic              rom_ready,
  input  logic              ram_ready,
  input  logic              per_ready,
  input  logic [31:0]       rom_rdata,
  input  logic [31:0]       ram_rdata,
  input  logic [31:0]       per_rdata,
  output logic              bus_err,
  output logic [31:0]       err_addr
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);
  state_t      state;
  logic [15:0] cnt;
  logic [31:0] req_addr;
  logic        rom_hit, ram_hit, per_hit, rdy;
  logic [31:0] rdata;
  always_comb begin
    rom_hit = mem_addr[31:12] == ROM_BASE[31:12];
    ram_hit = mem_addr[31:12] == RAM_BASE[31:12];
    per_hit = mem_addr[31:16] == PERIPH_BASE[31:16];
    rdy     = (rom_sel & rom_ready) | (ram_sel & ram_ready) | (per_sel & per_ready);
    rdata   = rom_sel ? rom_rdata : ram_sel ? ram_rdata : per_rdata;
  end
  // req_addr keeps the full address so a timeout reports it even if the CPU changed mem_addr
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_addr  <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      slv_wstrb <= '0;
      rom_sel   <= 1'b0;
      ram_sel   <= 1'b0;
      per_sel   <= 1'b0;
      bus_err   <= 1'b0;
      err_addr  <= '0;
    end else begin
      case (state)
        IDLE: if (mem_valid) begin
          if (rom_hit | ram_hit | per_hit) begin
            slv_addr  <= mem_addr[SLV_AW+1:2];
            slv_wdata <= mem_wdata;
            slv_wstrb <= mem_wstrb;
            req_addr  <= mem_addr;
            rom_sel   <= rom_hit;
            ram_sel   <= !rom_hit && ram_hit;
            per_sel   <= !rom_hit && !ram_hit;
            cnt       <= '0;
            state     <= ACCESS;
          end else begin
            mem_ready <= 1'b1;
            mem_rdata <= ERR_DATA;
            bus_err   <= 1'b1;
            err_addr  <= mem_addr;
            state     <= RESP;
          end
        end
        ACCESS: if (rdy || cnt == TLAST) begin
          rom_sel   <= 1'b0;
          ram_sel   <= 1'b0;
          per_sel   <= 1'b0;
          mem_ready <= 1'b1;
          mem_rdata <= rdy ? rdata : ERR_DATA;
          bus_err   <= !rdy;
          err_addr  <= rdy ? err_addr : req_addr;
          state     <= RESP;
        end else begin
          cnt <= cnt + 16'd1;
        end
        RESP: begin
          mem_ready <= 1'b0;
          bus_err   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
